// File: rtl/fsmc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fsmc_mem_arbiter                                                |
// | Purpose  : Shares the single-port FSMC buffer RAM between the host strobe  |
// |            path (auto-incrementing index) and one addressed device port.   |
// |            Optional macro FSMC_ARB_FAIR_EN adds a device fairness flag.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fsmc_mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_wr,
    input  logic          host_rd,
    input  logic [1:0]    host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] index,
    output logic          host_busy,
    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic          dev_ack,
    output logic [DW-1:0] dev_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0]    c_st_idle    = 2'd0;
    localparam logic [1:0]    c_st_host_wr = 2'd1;
    localparam logic [1:0]    c_st_host_rd = 2'd2;
    localparam logic [1:0]    c_st_dev     = 2'd3;
    localparam logic [AW-1:0] c_idx_one    = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_pend_wr;
    logic          r_pend_rd;
    logic [DW-1:0] r_wr_data;
    logic [AW-1:0] r_index;
    logic          r_rd_phase;
    logic          r_ack_phase;
    logic          r_ack_we;
    logic [DW-1:0] r_host_rdata;
    logic [DW-1:0] r_dev_rdata;

    logic w_strobe_wr;
    logic w_load_idx;
    logic w_req_wr;
    logic w_req_rd;
    logic w_dev_elig;
    logic w_dev_first;
    logic w_host_grant;
    logic w_in_host;

    // Raw strobes join arbitration directly so a host op can issue the very next cycle.
    assign w_strobe_wr  = host_wr && (host_addr == 2'b00);
    assign w_load_idx   = host_wr && host_addr[1];
    assign w_req_wr     = r_pend_wr || w_strobe_wr;
    assign w_req_rd     = r_pend_rd || host_rd;
    assign w_dev_elig   = dev_req && (r_state != c_st_dev);
    assign w_host_grant = (w_state_nxt == c_st_host_wr) || (w_state_nxt == c_st_host_rd);
    assign w_in_host    = (r_state == c_st_host_wr) || (r_state == c_st_host_rd);

`ifdef FSMC_ARB_FAIR_EN
    logic r_fair;

    assign w_dev_first = r_fair && w_dev_elig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fair <= 1'b0;
        end else if (w_state_nxt == c_st_dev) begin
            r_fair <= 1'b0;
        end else if (w_host_grant && dev_req) begin
            r_fair <= 1'b1;
        end
    end
`else
    assign w_dev_first = 1'b0;
`endif

    always_comb begin
        w_state_nxt = c_st_idle;
        if (w_dev_first) begin
            w_state_nxt = c_st_dev;
        end else if (w_req_wr) begin
            w_state_nxt = c_st_host_wr;
        end else if (w_req_rd) begin
            w_state_nxt = c_st_host_rd;
        end else if (w_dev_elig) begin
            w_state_nxt = c_st_dev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_pend_wr    <= 1'b0;
            r_pend_rd    <= 1'b0;
            r_wr_data    <= '0;
            r_index      <= '0;
            r_rd_phase   <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_ack_we     <= 1'b0;
            r_host_rdata <= '0;
            r_dev_rdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_wr <= w_req_wr && (w_state_nxt != c_st_host_wr);
            r_pend_rd <= w_req_rd && (w_state_nxt != c_st_host_rd);
            if (w_strobe_wr) begin
                r_wr_data <= host_wdata;
            end
            // A load coinciding with a grant's exit overrides that grant's increment.
            if (w_load_idx) begin
                r_index <= host_wdata[AW-1:0];
            end else if (w_in_host) begin
                r_index <= r_index + c_idx_one;
            end
            r_rd_phase  <= (r_state == c_st_host_rd);
            r_ack_phase <= (r_state == c_st_dev);
            if (r_state == c_st_dev) begin
                r_ack_we <= dev_we;
            end
            if (r_rd_phase) begin
                r_host_rdata <= mem_rdata;
            end
            if (r_ack_phase && !r_ack_we) begin
                r_dev_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            c_st_host_wr: begin
                mem_addr  = r_index;
                mem_we    = 1'b1;
                mem_wdata = r_wr_data;
            end
            c_st_host_rd: begin
                mem_addr = r_index;
            end
            c_st_dev: begin
                mem_addr = dev_addr;
                mem_we   = dev_we;
                if (dev_we) begin
                    mem_wdata = dev_wdata;
                end
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    // RAM data arrives in the ack cycle, so it is passed through then and held afterwards.
    assign dev_rdata  = (r_ack_phase && !r_ack_we) ? mem_rdata : r_dev_rdata;
    assign dev_ack    = r_ack_phase;
    assign host_rdata = r_host_rdata;
    assign index      = r_index;
    assign host_busy  = r_pend_wr || r_pend_rd || w_in_host;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fsmc_mem_arbiter                                             |
// | Purpose  : Scoreboard bench for fsmc_mem_arbiter with a behavioural RAM.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fsmc_mem_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int NPAIR = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] data;
    } dev_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_wr, host_rd;
    logic [1:0]    host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic [AW-1:0] index;
    logic          host_busy;
    logic          dev_req, dev_we;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata, dev_rdata;
    logic          dev_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram [0:511];
    logic [DW-1:0] shadow [0:511];
    wr_exp_t       q_wr [$];
    dev_exp_t      q_dev [$];
    wr_exp_t       mon_w;
    dev_exp_t      mon_d;
    logic [AW-1:0] m_index;
    logic          keep;
    int            n_win_acks;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    fsmc_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .index(index),
        .host_busy(host_busy),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: RAM writes and device completions.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            check("memwr_expected", 32'(q_wr.size() != 0), 32'd1);
            if (q_wr.size() != 0) begin
                mon_w = q_wr.pop_front();
                check("memwr_addr", 32'(mem_addr), 32'(mon_w.addr));
                check("memwr_data", 32'(mem_wdata), 32'(mon_w.data));
            end
        end
        if (!reset && dev_ack) begin
            check("devack_expected", 32'(q_dev.size() != 0), 32'd1);
            if (q_dev.size() != 0) begin
                mon_d = q_dev.pop_front();
                if (!mon_d.we) check("dev_rdata", 32'(dev_rdata), 32'(mon_d.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        q_wr.push_back(e);
        shadow[a] = d;
    endtask

    task automatic push_dev(input logic we, input logic [DW-1:0] d);
        dev_exp_t e;
        e.we   = we;
        e.data = d;
        q_dev.push_back(e);
    endtask

    task automatic host_load_index(input logic [AW-1:0] v);
        host_addr  = 2'b10;
        host_wdata = DW'(v);
        host_wr    = 1'b1;
        tick();
        host_wr = 1'b0;
        m_index = v;
        check("index_load", 32'(index), 32'(v));
        tick();
    endtask

    task automatic host_write(input logic [DW-1:0] d);
        push_wr(m_index, d);
        host_addr  = 2'b00;
        host_wdata = d;
        host_wr    = 1'b1;
        tick();
        host_wr = 1'b0;
        m_index = m_index + 9'd1;
        tick();
        tick();
    endtask

    task automatic host_read();
        logic [DW-1:0] exp_d;
        exp_d   = shadow[m_index];
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        check("rd_issue_addr", 32'(mem_addr), 32'(m_index));
        check("rd_busy", 32'(host_busy), 32'd1);
        tick();
        m_index = m_index + 9'd1;
        check("rd_index_inc", 32'(index), 32'(m_index));
        tick();
        check("host_rdata", 32'(host_rdata), 32'(exp_d));
    endtask

    task automatic dev_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int exp_lat);
        int n;
        push_dev(we, we ? d : shadow[a]);
        if (we) push_wr(a, d);
        dev_we    = we;
        dev_addr  = a;
        dev_wdata = d;
        dev_req   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!dev_ack && n < 20);
        dev_req = 1'b0;
        check("dev_latency", 32'(n), 32'(exp_lat));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] base;
        reset = 1'b1;
        host_wr = 1'b0; host_rd = 1'b0; host_addr = 2'b00; host_wdata = '0;
        dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
        keep = 1'b0; n_win_acks = 0; m_index = '0;
        for (int i = 0; i < 512; i++) shadow[i] = '0;
        repeat (3) tick();
        check("rst_index", 32'(index), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_dev_ack", 32'(dev_ack), 32'd0);
        check("rst_dev_rdata", 32'(dev_rdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(host_busy), 32'd0);
        reset = 1'b0;
        tick();

        // Index wrap across the top of the buffer.
        host_load_index(9'h1FE);
        host_write(16'hAAAA);
        host_write(16'h5555);
        check("index_wrap", 32'(index), 32'h000);

        // Device write then read with no host traffic.
        dev_access(1'b1, 9'h020, 16'hBEEF, 2);
        dev_access(1'b0, 9'h020, 16'h0000, 2);
        dev_access(1'b0, 9'h1FE, 16'h0000, 2);
        dev_access(1'b0, 9'h1FF, 16'h0000, 2);

        // Host read with prefetch latency.
        host_load_index(9'h010);
        host_write(16'h1234);
        host_load_index(9'h010);
        host_read();

        // Host write and device request in the same cycle.
        push_wr(m_index, 16'h0F0F);
        push_dev(1'b0, shadow[9'h020]);
        host_addr = 2'b00; host_wdata = 16'h0F0F; host_wr = 1'b1;
        dev_we = 1'b0; dev_addr = 9'h020; dev_req = 1'b1;
        tick();
        host_wr = 1'b0;
        check("cc_host_first_we", 32'(mem_we), 32'd1);
        check("cc_host_first_addr", 32'(mem_addr), 32'(m_index));
        tick();
        check("cc_dev_next_addr", 32'(mem_addr), 32'h020);
        check("cc_dev_no_ack_yet", 32'(dev_ack), 32'd0);
        tick();
        check("cc_dev_ack", 32'(dev_ack), 32'd1);
        dev_req = 1'b0;
        m_index = m_index + 9'd1;
        tick();

        // Index load landing in a write grant's exit cycle overrides the increment.
        push_wr(m_index, 16'h7777);
        host_addr = 2'b00; host_wdata = 16'h7777; host_wr = 1'b1;
        tick();
        host_addr = 2'b10; host_wdata = 16'h0100;
        tick();
        host_wr = 1'b0;
        m_index = 9'h100;
        check("load_wins", 32'(index), 32'h100);
        tick();

        // Continuous host traffic against a held device request.
        host_load_index(9'h040);
        base = 9'h040;
        keep = 1'b1;
        fork
            begin
                for (int k = 0; k < NPAIR; k++) begin
                    logic [AW-1:0] a;
`ifdef FSMC_ARB_FAIR_EN
                    a = base + 9'(k);
`else
                    a = base + 9'(2 * k);
`endif
                    push_wr(a, 16'h3000 + 16'(k));
                    host_addr = 2'b00; host_wdata = 16'h3000 + 16'(k);
                    host_wr = 1'b1; host_rd = 1'b1;
                    tick();
                    host_wr = 1'b0; host_rd = 1'b0;
                    tick();
                end
                keep = 1'b0;
            end
            begin
                logic done;
                done = 1'b0;
                dev_we = 1'b0; dev_addr = 9'h020;
                push_dev(1'b0, shadow[9'h020]);
                dev_req = 1'b1;
                for (int i = 0; i < 200 && !done; i++) begin
                    tick();
                    if (dev_ack) begin
                        if (keep) begin
                            n_win_acks++;
                            push_dev(1'b0, shadow[9'h020]);
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                dev_req = 1'b0;
                check("stream_dev_done", 32'(done), 32'd1);
            end
        join
        tick();
        tick();
`ifdef FSMC_ARB_FAIR_EN
        check("stream_dev_acks", 32'(n_win_acks), 32'(NPAIR - 1));
        m_index = base + 9'(NPAIR + 1);
`else
        check("stream_dev_acks", 32'(n_win_acks), 32'd0);
        m_index = base + 9'(2 * NPAIR);
`endif
        check("stream_index", 32'(index), 32'(m_index));

        // Reset in a device issue cycle abandons the access.
        dev_we = 1'b0; dev_addr = 9'h020; dev_req = 1'b1;
        tick();
        check("rst_dev_issue_addr", 32'(mem_addr), 32'h020);
        reset = 1'b1;
        dev_req = 1'b0;
        tick();
        check("rst2_dev_ack", 32'(dev_ack), 32'd0);
        check("rst2_dev_rdata", 32'(dev_rdata), 32'd0);
        check("rst2_host_rdata", 32'(host_rdata), 32'd0);
        check("rst2_index", 32'(index), 32'd0);
        check("rst2_mem_addr", 32'(mem_addr), 32'd0);
        check("rst2_mem_we", 32'(mem_we), 32'd0);
        check("rst2_busy", 32'(host_busy), 32'd0);
        reset = 1'b0;
        tick();
        check("rst3_dev_ack", 32'(dev_ack), 32'd0);
        tick();
        tick();

        check("wr_queue_drained", 32'(q_wr.size()), 32'd0);
        check("dev_queue_drained", 32'(q_dev.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
